// File: rtl/mul32_seq.sv
`timescale 1ns/1ps
// Iterative unsigned WIDTHxWIDTH -> 2*WIDTH shift-add multiplier driving an external shared adder.
// One product per START: 32 iteration cycles, then a one-cycle DONE pulse with PRODUCT held afterwards.
module mul32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   OP_A,
  input  logic [WIDTH-1:0]   OP_B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0]   ADD_IN1,
  output logic [WIDTH-1:0]   ADD_IN2,
  output logic               ADD_CIN,
  input  logic [WIDTH-1:0]   ADD_OUT,
  input  logic               ADD_COUT
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;

  // Adder carry is the top bit of the partial sum; the multiplier bit consumed falls off the bottom.
  assign shifted   = {ADD_COUT, ADD_OUT, acc_lo[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY    = 1'b0;
    DONE    = 1'b0;
    ADD_IN1 = '0;
    ADD_IN2 = '0;
    ADD_CIN = 1'b0;
    case (state)
      CALC: begin
        BUSY    = 1'b1;
        ADD_IN1 = acc_hi;
        ADD_IN2 = acc_lo[0] ? mcand : '0;
      end
      FIN: begin
        BUSY = 1'b1;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      PRODUCT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            mcand  <= OP_A;
            acc_lo <= OP_B;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt + CNT_W'(1);
          if (last_iter) PRODUCT <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule
